// File: rtl/dram.sv
// rtl/dram.sv - behavioural DRAM user-port model: masked writes, in-order fixed-latency reads
// Optional DRAM_ZERO_INIT_EN: memory array starts at all-zero instead of X.

module dram_rd_fifo #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] pop_data_q, pop_data_d;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pop_data_d = pop  ? fifo_mem[rd_ptr_q] : pop_data_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pop_data_q <= pop_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    // count never exceeds DEPTH, so its top bit alone marks full
    assign full     = count_q[AW];
    assign empty    = (count_q == '0);
    assign pop_data = pop_data_q;
endmodule

module dram #(
    parameter int APP_ADDR_WIDTH  = 28,
    parameter int APP_DATA_WIDTH  = 128,
    parameter int APP_MASK_WIDTH  = 16,
    parameter int MEM_ADDR_WIDTH  = 16,
    parameter int FIFO_ADDR_WIDTH = 3,
    parameter int READ_LATENCY    = 16,
    parameter int CALIB_CYCLES    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ren,
    input  logic                      i_wen,
    input  logic [APP_ADDR_WIDTH-2:0] i_addr,
    input  logic [APP_DATA_WIDTH-1:0] i_data,
    input  logic [APP_MASK_WIDTH-1:0] i_mask,
    input  logic                      i_busy,
    output logic                      o_init_calib_complete,
    output logic [APP_DATA_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic                      o_busy
);
    localparam int MEM_WORDS = 1 << MEM_ADDR_WIDTH;
    localparam int LAT_W     = $clog2(READ_LATENCY);
    localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 2);
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

`ifdef DRAM_ZERO_INIT_EN
    logic [APP_DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};
`else
    logic [APP_DATA_WIDTH-1:0] mem [MEM_WORDS];
`endif

    logic [CAL_W-1:0]          cal_cnt_q, cal_cnt_d;
    logic                      calib_q, calib_d;
    logic [1:0]                state_q, state_d;
    logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
    logic                      valid_q, valid_d;
    logic [APP_DATA_WIDTH-1:0] data_q, data_d;

    logic                      wr_en, push, pop, fifo_full, fifo_empty;
    logic [MEM_ADDR_WIDTH-1:0] cmd_word, rd_word;
    logic [APP_DATA_WIDTH-1:0] rd_merge;
    logic                      unused_addr_bits;

    assign cmd_word         = i_addr[MEM_ADDR_WIDTH+2:3];
    assign unused_addr_bits = ^{i_addr[2:0], i_addr[APP_ADDR_WIDTH-2:MEM_ADDR_WIDTH+3]};

    assign o_busy = i_rst | ~calib_q | fifo_full;
    assign wr_en  = i_wen & ~o_busy;
    assign push   = i_ren & ~o_busy;
    assign pop    = ~i_rst & (state_q == ST_IDLE) & ~fifo_empty;

    dram_rd_fifo #(
        .DW (MEM_ADDR_WIDTH),
        .AW (FIFO_ADDR_WIDTH)
    ) u_rd_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (cmd_word),
        .pop       (pop),
        .pop_data  (rd_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int k = 0; k < APP_MASK_WIDTH; k++) begin
                if (!i_mask[k]) begin
                    mem[cmd_word][k*8 +: 8] <= i_data[k*8 +: 8];
                end
            end
        end
    end

    // read sees the write landing on the same edge
    always_comb begin
        rd_merge = mem[rd_word];
        if (wr_en && (cmd_word == rd_word)) begin
            for (int k = 0; k < APP_MASK_WIDTH; k++) begin
                if (!i_mask[k]) begin
                    rd_merge[k*8 +: 8] = i_data[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        cal_cnt_d = calib_q ? cal_cnt_q : cal_cnt_q + 1'b1;
        calib_d   = calib_q | (cal_cnt_q == CAL_LAST);
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d   = ST_WAIT;
                    lat_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    data_d  = rd_merge;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!i_busy) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            cal_cnt_q <= cal_cnt_d;
            calib_q   <= calib_d;
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    assign o_init_calib_complete = calib_q;
    assign o_data_valid          = valid_q;
    assign o_data                = data_q;
endmodule

// File: tb/tb_dram.sv
// tb/tb_dram.sv - directed scoreboard bench for the dram user-port model
module tb_dram;
    logic         clk = 1'b0;
    logic         rst, ren, wen, busy_in;
    logic [26:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  mask;
    logic         calib, rvalid, obusy;
    logic [127:0] rdata;

    always #5 clk = ~clk;

    dram dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_ren                 (ren),
        .i_wen                 (wen),
        .i_addr                (addr),
        .i_data                (wdata),
        .i_mask                (mask),
        .i_busy                (busy_in),
        .o_init_calib_complete (calib),
        .o_data                (rdata),
        .o_data_valid          (rvalid),
        .o_busy                (obusy)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc;
    logic [127:0] model [int];
    logic [127:0] exp_q [$];
    int           beat_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rvalid && !busy_in) begin
            beat_cyc.push_back(cyc);
            check("beat_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) check("rd_data", rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free(input string tag);
        int n = 0;
        while (obusy && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_accept"}, 128'(obusy), 128'd0);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beat_cyc.size() < n && t < 2000) begin
            tick();
            t++;
        end
        check("beat_timeout", 128'(beat_cyc.size() >= n), 128'd1);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!rvalid && t < 100) begin
            tick();
            t++;
        end
        check("valid_timeout", 128'(rvalid), 128'd1);
    endtask

    task automatic do_write(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
        int w;
        logic [127:0] word;
        wen = 1'b1; addr = a; wdata = d; mask = m;
        wait_free("wr");
        tick();
        wen = 1'b0;
        w = int'(a[18:3]);
        word = model.exists(w) ? model[w] : 'x;
        for (int k = 0; k < 16; k++) if (!m[k]) word[k*8 +: 8] = d[k*8 +: 8];
        model[w] = word;
    endtask

    task automatic do_read(input logic [26:0] a);
        ren = 1'b1; addr = a;
        wait_free("rd");
        acc_cyc = cyc;
        exp_q.push_back(model[int'(a[18:3])]);
        tick();
        ren = 1'b0;
    endtask

    initial begin
        int a2, b, nb;
        rst = 1'b1; ren = 1'b0; wen = 1'b0; busy_in = 1'b0;
        addr = '0; wdata = '0; mask = '0;

        // reset and calibration window
        repeat (4) tick();
        check("rst_calib", 128'(calib), 128'd0);
        check("rst_valid", 128'(rvalid), 128'd0);
        check("rst_data", rdata, 128'd0);
        check("rst_busy", 128'(obusy), 128'd1);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("calib_low", 128'(calib), 128'd0);
            check("busy_calib", 128'(obusy), 128'd1);
            tick();
        end
        check("calib_high", 128'(calib), 128'd1);
        check("busy_ready", 128'(obusy), 128'd0);

        // full write then read: latency and single pulse
        do_write(27'h10, 128'h0000_0000_0000_0000_0033_2222_1111_0000, 16'h0000);
        do_read(27'h10);
        a2 = acc_cyc;
        wait_beats(1);
        check("rd_latency", 128'(beat_cyc[0] - a2), 128'd17);
        check("valid_pulse", 128'(rvalid), 128'd0);

        // partial write touches only bytes 0-3
        do_write(27'h10, {128{1'b1}}, 16'hFFF0);
        check("model_partial", model[2], 128'h0000_0000_0000_0000_0033_2222_FFFF_FFFF);
        do_read(27'h10);
        wait_beats(2);

        // ten back-to-back reads fill the FIFO
        for (int i = 0; i < 10; i++)
            do_write(27'(i * 8), {$urandom, $urandom, $urandom, $urandom}, 16'h0000);
        b = beat_cyc.size();
        for (int i = 0; i < 10; i++) begin
            do_read(27'(i * 8));
            if (i == 0) a2 = acc_cyc;
            if (i == 8) check("fifo_full_busy", 128'(obusy), 128'd1);
        end
        wait_beats(b + 10);
        check("burst_first_latency", 128'(beat_cyc[b] - a2), 128'd17);
        for (int i = 1; i < 10; i++)
            check("burst_spacing", 128'(beat_cyc[b+i] - beat_cyc[b+i-1]), 128'd17);

        // user back-pressure holds the beat and delays the next one
        busy_in = 1'b1;
        do_read(27'h00);
        do_read(27'h08);
        wait_valid();
        b = beat_cyc.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 128'(rvalid), 128'd1);
            check("hold_data", rdata, exp_q[0]);
        end
        check("hold_no_consume", 128'(beat_cyc.size()), 128'(b));
        busy_in = 1'b0;
        wait_beats(b + 2);
        check("hold_next_spacing", 128'(beat_cyc[b+1] - beat_cyc[b]), 128'd17);

        // reset with reads outstanding
        busy_in = 1'b1;
        do_read(27'h10);
        do_read(27'h18);
        do_read(27'h20);
        wait_valid();
        rst = 1'b1;
        tick();
        check("rst2_valid", 128'(rvalid), 128'd0);
        check("rst2_data", rdata, 128'd0);
        check("rst2_calib", 128'(calib), 128'd0);
        check("rst2_busy", 128'(obusy), 128'd1);
        exp_q.delete();
        busy_in = 1'b0;
        tick();
        rst = 1'b0;
        nb = beat_cyc.size();
        repeat (32) tick();
        check("rst2_calib_high", 128'(calib), 128'd1);
        repeat (40) tick();
        check("no_stale_beats", 128'(beat_cyc.size()), 128'(nb));
        do_read(27'h10);
        wait_beats(nb + 1);

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
